// File: rtl/multicore_pkg.sv
// Shared encodings, state types and slot timing helper for the multi-core scheduler.
package multicore_pkg;

  localparam logic [1:0] ST_STOP   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_SINGLE = 2'b10;
  localparam logic [1:0] ST_ABORT  = 2'b11;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} top_state_t;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_START, S_WAIT, S_WRITE} slot_state_t;

  // Cycles a slot spends on one task, excluding the wait for core_done.
  function automatic int unsigned slot_latency(input int unsigned read_cycles,
                                               input int unsigned wr_per_core);
    return read_cycles + 1 + wr_per_core + 1;
  endfunction

endpackage

// File: rtl/core_slot_fsm.sv
// One core slot: operand read, start pulse, completion wait and one-hot result write.
//   state   | meaning
//   S_IDLE  | free, may be assigned a task this cycle
//   S_READ  | read_en held for READ_CYCLES cycles
//   S_START | one-cycle core_start
//   S_WAIT  | waiting for core_done
//   S_WRITE | write_en walks one-hot across the group
module core_slot_fsm
  import multicore_pkg::*;
#(
  parameter int READ_CYCLES = 2,
  parameter int WR_PER_CORE = 4,
  parameter int TASK_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   abort,
  input  logic                   assign_task,
  input  logic [TASK_W-1:0]      task_in,
  input  logic                   core_done,
  output logic                   idle,
  output logic                   core_start,
  output logic                   read_en,
  output logic [WR_PER_CORE-1:0] write_en,
  output logic [TASK_W-1:0]      task_id
);

  localparam int CNT_MAX = (READ_CYCLES > WR_PER_CORE) ? READ_CYCLES : WR_PER_CORE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  slot_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] wr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      task_id <= '0;
    end else if (abort) begin
      state   <= S_IDLE;
      cnt     <= '0;
      task_id <= '0;
    end else if (ena) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (assign_task) task_id <= task_in;
    end
  end

  // Down-counters: loaded on entry, state advances at terminal count zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (assign_task) begin
          state_nxt = S_READ;
          cnt_nxt   = CNT_W'(READ_CYCLES - 1);
        end
      end
      S_READ: begin
        if (cnt == '0) state_nxt = S_START;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          state_nxt = S_WRITE;
          cnt_nxt   = CNT_W'(WR_PER_CORE - 1);
        end
      end
      S_WRITE: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    idle       = (state == S_IDLE);
    read_en    = ena && (state == S_READ);
    core_start = ena && (state == S_START);
    wr_sel     = CNT_W'(WR_PER_CORE - 1) - cnt;
    write_en   = '0;
    if (ena && state == S_WRITE) write_en = WR_PER_CORE'(1) << wr_sel;
  end

endmodule

// File: rtl/multicore_scheduler.sv
// Round-robin task dispatcher over NUM_CORES slots with job-level completion tracking.
//   state    | meaning
//   IDLE     | waiting for a 00 -> 01/10 status transition
//   DISPATCH | handing tasks to the lowest free slot, one per cycle
//   DRAIN    | all tasks issued, waiting for every slot to go idle
//   DONE     | job complete, z high until status returns to 00
module multicore_scheduler
  import multicore_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int WR_PER_CORE = 4,
  parameter int READ_CYCLES = 2,
  parameter int TASK_W      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic [1:0]                       status,
  input  logic [TASK_W-1:0]                num_tasks,
  input  logic [NUM_CORES-1:0]             core_done,
  output logic [NUM_CORES-1:0]             core_start,
  output logic [NUM_CORES*TASK_W-1:0]      task_id,
  output logic [NUM_CORES-1:0]             read_en,
  output logic [NUM_CORES*WR_PER_CORE-1:0] write_en,
  output logic [NUM_CORES-1:0]             end_process,
  output logic                             z,
  output logic                             busy
);

  top_state_t           state, state_nxt;
  logic [1:0]           status_prev;
  logic                 single_q;
  logic [TASK_W-1:0]    num_q, next_task, total;
  logic [NUM_CORES-1:0] quota_used, slot_idle, eligible, grant;
  logic                 abort, start, dispatch_go;

  assign abort       = (status == ST_ABORT);
  assign start       = ena && (status_prev == ST_STOP) && (status == ST_RUN || status == ST_SINGLE);
  assign total       = (single_q && num_q > TASK_W'(NUM_CORES)) ? TASK_W'(NUM_CORES) : num_q;
  assign eligible    = slot_idle & ~(quota_used & {NUM_CORES{single_q}});
  assign dispatch_go = ena && !abort && (state == DISPATCH) && (next_task != total);
  // Isolate the lowest set bit of eligible.
  assign grant       = dispatch_go ? (eligible & (~eligible + NUM_CORES'(1))) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              state <= IDLE;
    else if (ena || abort)   state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_nxt = DISPATCH;
        DISPATCH: if (next_task == total) state_nxt = (total == '0) ? DONE : DRAIN;
        DRAIN:    if (&slot_idle) state_nxt = DONE;
        DONE:     if (status == ST_STOP) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_prev <= ST_STOP;
      single_q    <= 1'b0;
      num_q       <= '0;
      next_task   <= '0;
      quota_used  <= '0;
    end else if (ena) begin
      status_prev <= status;
      if (abort) begin
        next_task  <= '0;
        quota_used <= '0;
      end else if (state == IDLE && start) begin
        num_q      <= num_tasks;
        single_q   <= (status == ST_SINGLE);
        next_task  <= '0;
        quota_used <= '0;
      end else if (|grant) begin
        next_task  <= next_task + TASK_W'(1);
        quota_used <= quota_used | grant;
      end
    end
  end

  always_comb begin
    busy        = (state == DISPATCH) || (state == DRAIN);
    z           = (state == DONE);
    end_process = '0;
    if (state == DRAIN || state == DONE)  end_process = slot_idle;
    else if (state == DISPATCH && single_q) end_process = slot_idle & quota_used;
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    core_slot_fsm #(
      .READ_CYCLES (READ_CYCLES),
      .WR_PER_CORE (WR_PER_CORE),
      .TASK_W      (TASK_W)
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .abort       (abort),
      .assign_task (grant[i]),
      .task_in     (next_task),
      .core_done   (core_done[i]),
      .idle        (slot_idle[i]),
      .core_start  (core_start[i]),
      .read_en     (read_en[i]),
      .write_en    (write_en[i*WR_PER_CORE +: WR_PER_CORE]),
      .task_id     (task_id[i*TASK_W +: TASK_W])
    );
  end

endmodule

// File: tb/tb_multicore_scheduler.sv
// Self-checking bench: cycle table for the first job, scoreboard of (core, task) for later jobs.
`timescale 1ns/1ps
module tb_multicore_scheduler;
  import multicore_pkg::*;

  localparam int NC = 4, WR = 4, RC = 2, TW = 8, CW = 2, DONE_DLY = 5;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [1:0] status = ST_STOP;
  logic [TW-1:0] num_tasks = '0;
  logic [NC-1:0] done_man = '0, done_auto = '0, core_done;
  logic [NC-1:0] core_start, read_en, end_process;
  logic [NC*TW-1:0] task_id;
  logic [NC*WR-1:0] write_en;
  logic z, busy;

  assign core_done = done_man | done_auto;
  always #5 clk = ~clk;

  multicore_scheduler #(.NUM_CORES(NC), .WR_PER_CORE(WR), .READ_CYCLES(RC), .TASK_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .status(status), .num_tasks(num_tasks),
    .core_done(core_done), .core_start(core_start), .task_id(task_id), .read_en(read_en),
    .write_en(write_en), .end_process(end_process), .z(z), .busy(busy)
  );

  typedef struct packed {
    logic [NC-1:0]    done;
    logic [NC-1:0]    rd;
    logic [NC-1:0]    st;
    logic [NC*WR-1:0] wr;
    logic             busy;
    logic             z;
    logic [NC-1:0]    ep;
  } vec_t;

  typedef struct packed {
    logic [CW-1:0] core;
    logic [TW-1:0] tid;
  } exp_t;

  vec_t tbl[20];
  exp_t sb[$];
  int checks = 0, passed = 0;
  bit mon_on = 0, auto_done = 0;
  int dcnt[NC];
  int rd_total = 0, st_total = 0, wr_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] d, input logic [3:0] rd, input logic [3:0] st,
                              input logic [15:0] wr, input logic b, input logic zz, input logic [3:0] ep);
    vec_t v;
    v.done = d; v.rd = rd; v.st = st; v.wr = wr; v.busy = b; v.z = zz; v.ep = ep;
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] mode, input int num);
    int total = (mode == ST_SINGLE && num > NC) ? NC : num;
    cyc(); status = ST_STOP;
    cyc(); status = ST_STOP;
    cyc(); status = mode; num_tasks = TW'(num);
    for (int j = 0; j < total; j++) sb.push_back('{core: CW'(j % NC), tid: TW'(j)});
  endtask

  task automatic wait_z(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (z) break;
      n++;
    end
    check("z_reached", 64'(z), 64'(1));
  endtask

  // Core model and monitor: answers core_start with core_done DONE_DLY cycles later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      rd_total += $countones(read_en);
      st_total += $countones(core_start);
      wr_total += $countones(write_en);
      for (int i = 0; i < NC; i++) begin
        done_auto[i] = 1'b0;
        if (dcnt[i] > 0) begin
          dcnt[i]--;
          if (dcnt[i] == 0) done_auto[i] = auto_done;
        end
        if (core_start[i]) begin
          dcnt[i] = DONE_DLY;
          if (mon_on) begin
            if (sb.size() == 0) begin
              checks++;
              $display("FAIL sb_extra_start: core %0d started, no task expected", i);
            end else begin
              e = sb.pop_front();
              check("sb_core", 64'(i), 64'(e.core));
              check("sb_task", 64'(task_id[i*TW +: TW]), 64'(e.tid));
            end
          end
        end
        if (mon_on && write_en[i*WR +: WR] != '0)
          check("wr_onehot", 64'($onehot(write_en[i*WR +: WR])), 64'(1));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int st0, rd0, act0;
    //              done   rd     st     wr        b  z  ep
    tbl[0]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 0, 0, 4'h0);
    tbl[1]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 4'h0);
    tbl[2]  = mk(4'h0, 4'h1, 4'h0, 16'h0000, 1, 0, 4'h0);
    tbl[3]  = mk(4'h0, 4'h3, 4'h0, 16'h0000, 1, 0, 4'h0);
    tbl[4]  = mk(4'h0, 4'h6, 4'h1, 16'h0000, 1, 0, 4'h0);
    tbl[5]  = mk(4'h0, 4'hC, 4'h2, 16'h0000, 1, 0, 4'h0);
    tbl[6]  = mk(4'h0, 4'h8, 4'h4, 16'h0000, 1, 0, 4'h0);
    tbl[7]  = mk(4'h0, 4'h0, 4'h8, 16'h0000, 1, 0, 4'h0);
    tbl[8]  = mk(4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 4'h0);
    tbl[9]  = mk(4'h1, 4'h0, 4'h0, 16'h0000, 1, 0, 4'h0);
    tbl[10] = mk(4'h2, 4'h0, 4'h0, 16'h0001, 1, 0, 4'h0);
    tbl[11] = mk(4'h4, 4'h0, 4'h0, 16'h0012, 1, 0, 4'h0);
    tbl[12] = mk(4'h8, 4'h0, 4'h0, 16'h0124, 1, 0, 4'h0);
    tbl[13] = mk(4'h0, 4'h0, 4'h0, 16'h1248, 1, 0, 4'h0);
    tbl[14] = mk(4'h0, 4'h0, 4'h0, 16'h2480, 1, 0, 4'h1);
    tbl[15] = mk(4'h0, 4'h0, 4'h0, 16'h4800, 1, 0, 4'h3);
    tbl[16] = mk(4'h0, 4'h0, 4'h0, 16'h8000, 1, 0, 4'h7);
    tbl[17] = mk(4'h0, 4'h0, 4'h0, 16'h0000, 1, 0, 4'hF);
    tbl[18] = mk(4'h0, 4'h0, 4'h0, 16'h0000, 0, 1, 4'hF);
    tbl[19] = mk(4'h0, 4'h0, 4'h0, 16'h0000, 0, 1, 4'hF);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_outs", 64'({core_start, read_en, write_en, end_process, z, busy}), 64'(0));
    check("reset_task_id", 64'(task_id), 64'(0));

    // Job 1: four tasks, cycle-exact table, core_done driven from the table.
    cyc(); status = ST_STOP; num_tasks = 8'd4;
    for (int r = 0; r < 20; r++) begin
      cyc(); status = ST_RUN; done_man = tbl[r].done;
      @(negedge clk);
      check($sformatf("vec%0d", r), 64'({read_en, core_start, write_en, busy, z, end_process}),
            64'({tbl[r].rd, tbl[r].st, tbl[r].wr, tbl[r].busy, tbl[r].z, tbl[r].ep}));
    end
    done_man = '0;
    check("job1_task_id", 64'(task_id), 64'({8'd3, 8'd2, 8'd1, 8'd0}));

    // Job 2: ten tasks, unlimited quota.
    mon_on = 1; auto_done = 1;
    st0 = st_total;
    start_job(ST_RUN, 10);
    wait_z(400);
    check("run10_starts", 64'(st_total - st0), 64'(10));
    check("run10_sb_empty", 64'(sb.size()), 64'(0));
    check("run10_end_process", 64'(end_process), 64'(4'hF));
    check("run10_task_id", 64'(task_id), 64'({8'd7, 8'd6, 8'd9, 8'd8}));

    // Job 3: single pass caps the job at one task per core.
    st0 = st_total;
    start_job(ST_SINGLE, 10);
    wait_z(200);
    check("single_starts", 64'(st_total - st0), 64'(4));
    check("single_sb_empty", 64'(sb.size()), 64'(0));
    check("single_end_process", 64'(end_process), 64'(4'hF));
    check("single_task_id", 64'(task_id), 64'({8'd3, 8'd2, 8'd1, 8'd0}));

    // Job 4: abort during the write phase, then a clean restart.
    start_job(ST_RUN, 4);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (write_en != '0) break;
    end
    check("abort_saw_write", 64'(write_en != '0), 64'(1));
    cyc(); status = ST_ABORT;
    cyc();
    @(negedge clk);
    check("abort_outs", 64'({core_start, read_en, write_en, end_process, z, busy}), 64'(0));
    check("abort_task_id", 64'(task_id), 64'(0));
    for (int n = 0; n < 3; n++) begin
      cyc();
      @(negedge clk);
      check("abort_hold", 64'({z, busy}), 64'(0));
    end
    check("abort_sb_empty", 64'(sb.size()), 64'(0));
    st0 = st_total;
    start_job(ST_RUN, 4);
    wait_z(200);
    check("restart_starts", 64'(st_total - st0), 64'(4));
    check("restart_task_id", 64'(task_id), 64'({8'd3, 8'd2, 8'd1, 8'd0}));

    // Job 5: ena low for three cycles in the middle of the read phase.
    start_job(ST_RUN, 1);
    rd0 = rd_total;
    cyc();
    cyc(); @(negedge clk);
    check("ena_read_first", 64'(read_en), 64'(4'h1));
    for (int n = 0; n < 3; n++) begin
      cyc(); ena = 1'b0; @(negedge clk);
      check("ena_frozen", 64'({read_en, core_start, write_en}), 64'(0));
    end
    cyc(); ena = 1'b1; @(negedge clk);
    check("ena_read_resume", 64'({read_en, core_start}), 64'({4'h1, 4'h0}));
    cyc(); @(negedge clk);
    check("ena_start", 64'({read_en, core_start}), 64'({4'h0, 4'h1}));
    wait_z(100);
    check("ena_read_total", 64'(rd_total - rd0), 64'(RC));

    // Job 6: zero tasks finishes immediately with no slot activity.
    start_job(ST_RUN, 0);
    act0 = rd_total + st_total + wr_total;
    cyc(); @(negedge clk);
    check("zero_s1", 64'({z, busy}), 64'({1'b0, 1'b1}));
    cyc(); @(negedge clk);
    check("zero_s2", 64'({z, busy, end_process}), 64'({1'b1, 1'b0, 4'hF}));
    check("zero_activity", 64'(rd_total + st_total + wr_total - act0), 64'(0));

    // Asynchronous reset in the middle of a job.
    start_job(ST_RUN, 4);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (read_en != '0) break;
    end
    check("rst_saw_read", 64'(read_en != '0), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_outs", 64'({core_start, read_en, write_en, end_process, z, busy}), 64'(0));
    check("rst_async_task_id", 64'(task_id), 64'(0));
    mon_on = 0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    status = ST_STOP;
    @(negedge clk);
    check("rst_release_idle", 64'({busy, z, end_process}), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
